sha_mem_responder: RTL and testbench
====================================

Name: sha_mem_responder

Overview:
- Memory-side responder for the SHA-256 hasher's word-addressed memory interface.
- Owns a DEPTH-word synchronous RAM and accepts a NUM_OF_WORDS message over a valid/ready load stream.
- Pulses start to the hasher, serves its reads with one-cycle registered latency, and captures its 8 output-word writes into a 256-bit digest.
- Sits between the host/testbench stream and the hasher; it replaces the behavioural testbench memory.

Parameters:
DEPTH, 256, RAM size in 32-bit words; addresses >= DEPTH are out of range.
NUM_OF_WORDS, 20, message words accepted per load; must be 1..DEPTH.
MSG_BASE, 16'h0000, word address of message word 0; driven on message_addr.
OUT_BASE, 16'h0040, word address of digest word h0; driven on output_addr.

Ports:
clk  in  1  rising-edge clock; also the hasher's mem_clk domain.
reset  in  1  asynchronous, active-high reset.
load_valid  in  1  load word present.
load_data  in  32  load word.
load_ready  out  1  responder accepts a load word.
start  out  1  one-cycle start pulse to the hasher.
message_addr  out  16  constant MSG_BASE.
output_addr  out  16  constant OUT_BASE.
done  in  1  hasher done; level, high whenever the hasher is idle.
mem_we  in  1  hasher write enable.
mem_addr  in  16  hasher word address.
mem_write_data  in  32  hasher write data.
mem_read_data  out  32  registered read data.
digest  out  256  captured hash; h0 in [255:224], h7 in [31:0].
digest_valid  out  1  digest complete and hasher finished.
busy  out  1  high from the first accepted load word until RESULT.
err  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset (async, active-high) sets:
  - state=IDLE, start=0, digest=0, digest_valid=0, err=0, busy=0, mem_read_data=0.
  - load count=0, write mask=0.
  - RAM contents are not reset.
- load_ready = (state==IDLE || state==LOAD). A word transfers when load_valid && load_ready at a posedge.
- Read port:
  - Every posedge, mem_read_data <= RAM[mem_addr] if mem_addr<DEPTH, else 0.
  - Data for an address presented in cycle N appears in cycle N+1, regardless of state.
  - A read and a write to the same address in the same cycle return the old data.
- States:
  - IDLE: on the first transfer, write load_data to RAM[MSG_BASE], count=1, clear digest_valid, mask=0, set busy, go to LOAD. If NUM_OF_WORDS==1, go directly to START.
  - LOAD: each transfer writes RAM[MSG_BASE+count] and increments count. The transfer that makes count==NUM_OF_WORDS goes to START. load_valid low stalls the state indefinitely.
  - START: start=1 for exactly one cycle, then WAIT_ACK.
  - WAIT_ACK: stay until done==0 (the hasher left idle), then WAIT_DONE. No timeout.
  - WAIT_DONE: hasher writes are honoured. On done==1, go to RESULT. Set digest_valid=1 if mask==8'hFF; otherwise set err and leave digest_valid=0.
  - RESULT: busy=0. Hold digest and digest_valid. A new transfer behaves as in IDLE; the state then proceeds to LOAD, or to START if NUM_OF_WORDS==1.
- Hasher writes, taken when mem_we==1 at a posedge:
  - In WAIT_ACK or WAIT_DONE with mem_addr<DEPTH: RAM[mem_addr]<=mem_write_data.
  - If additionally OUT_BASE<=mem_addr<=OUT_BASE+7 with k=mem_addr-OUT_BASE: digest word k <= data and mask[k] <= 1. A repeated write to the same k overwrites.
  - mem_addr>=DEPTH: write dropped, err=1.
  - Writes in IDLE/LOAD/START/RESULT: dropped, err=1 (the loader owns the RAM in those states).
- Address arithmetic is 16-bit and wraps modulo 2^16 (MSG_BASE+count). Out-of-range loader addresses set err and drop the write.
- Simultaneous events:
  - A transfer on the last load cycle moves to START in the same edge; start is high the following cycle.
  - done falling in the same cycle start is high is legal and is seen in WAIT_ACK.
  - A write with done==1 in the same WAIT_DONE cycle is captured before the mask check (the write lands in the mask first).
- Reset mid-operation returns to IDLE immediately, aborts the load count and drops the digest; start deasserts asynchronously.

Test Plan:
- Load 20 words 0x00000000..0x00000013 with load_valid held high → load_ready high 20 cycles, start pulses once 1 cycle after the last transfer, busy=1; reading addresses 0..19 returns the same values, each 1 cycle after the address is driven.
- Hasher model drops done 2 cycles after start, writes 0x11111111..0x88888888 to 0x40..0x47, then raises done → digest=0x11111111_22222222_..._88888888 and digest_valid=1 on the cycle after done rises; busy=0.
- Same flow but the model writes only 0x40..0x46 → done rising gives err=1, digest_valid=0; err persists through a following clean run until reset.
- Hasher write to 0x0100 during WAIT_DONE and a write to 0x40 while IDLE → both dropped, err=1, RAM[0x40] unchanged.
- load_valid toggling every other cycle → exactly 20 transfers, start 1 cycle after the 20th; extra load_valid during WAIT_DONE sees load_ready=0.
- Assert reset during WAIT_DONE after 4 output writes → all outputs return to reset values asynchronously; a fresh 20-word load then completes normally with a new digest.

Source files
------------

// File: rtl/sha_mem_responder_if.sv
// Load stream and hasher memory bus between the host/bench and the SHA-256 memory responder.
// slave is the responder's view; master is the host/hasher side.
interface sha_mem_responder_if;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        start;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        done;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  load_valid, load_data, done, mem_we, mem_addr, mem_write_data,
        output load_ready, start, message_addr, output_addr, mem_read_data
    );

    modport master (
        output load_valid, load_data, done, mem_we, mem_addr, mem_write_data,
        input  load_ready, start, message_addr, output_addr, mem_read_data
    );
endinterface

// File: rtl/sha_mem_responder.sv
// Memory-side responder for the SHA-256 hasher: loads a message into RAM, starts the hasher,
// serves its reads with one-cycle latency and captures its eight digest-word writes.
module sha_mem_responder #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter logic [15:0] MSG_BASE     = 16'h0000,
    parameter logic [15:0] OUT_BASE     = 16'h0040
) (
    input  logic                  clk,
    input  logic                  reset,
    sha_mem_responder_if.slave    bus,
    output logic [255:0]          digest,
    output logic                  digest_valid,
    output logic                  busy,
    output logic                  err
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(NUM_OF_WORDS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, RESULT} state_t;
    state_t state, state_nxt;

    logic [31:0]      ram [DEPTH];
    logic [31:0]      rd_q;
    logic [CW-1:0]    count;
    logic [7:0]       mask;
    logic [7:0][31:0] dig_q;

    logic             load_ready_c;
    logic             start_c;
    logic             xfer;
    logic             first;
    logic             last_word;
    logic [15:0]      load_addr;
    logic             load_in_range;
    logic             hw_phase;
    logic             hw_in_range;
    logic             hw_wr;
    logic [15:0]      out_off;
    logic             cap;
    logic [7:0]       cap_bit;
    logic [7:0]       mask_now;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [31:0]      ram_wdata;

    assign bus.load_ready    = load_ready_c;
    assign bus.start         = start_c;
    assign bus.message_addr  = MSG_BASE;
    assign bus.output_addr   = OUT_BASE;
    assign bus.mem_read_data = rd_q;
    assign digest            = dig_q;

    // A transfer from IDLE or RESULT always lands on message word 0.
    assign xfer          = bus.load_valid && load_ready_c;
    assign first         = (state == IDLE) || (state == RESULT);
    assign load_addr     = first ? MSG_BASE : 16'(MSG_BASE + 16'(count));
    assign last_word     = first ? (NUM_OF_WORDS == 1) : (count == CW'(NUM_OF_WORDS - 1));
    assign load_in_range = 32'(load_addr) < DEPTH;

    assign hw_phase    = (state == WAIT_ACK) || (state == WAIT_DONE);
    assign hw_in_range = 32'(bus.mem_addr) < DEPTH;
    assign hw_wr       = bus.mem_we && hw_phase && hw_in_range;
    assign out_off     = 16'(bus.mem_addr - OUT_BASE);
    assign cap         = hw_wr && (out_off < 16'd8);
    assign cap_bit     = cap ? (8'b1 << out_off[2:0]) : '0;
    // Mask including this cycle's write, so a write coincident with done still counts.
    assign mask_now    = mask | cap_bit;

    assign ram_we    = (xfer && load_in_range) || hw_wr;
    assign ram_waddr = xfer ? load_addr[AW-1:0] : bus.mem_addr[AW-1:0];
    assign ram_wdata = xfer ? bus.load_data : bus.mem_write_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        load_ready_c = 1'b0;
        start_c      = 1'b0;
        case (state)
            IDLE, RESULT: begin
                load_ready_c = 1'b1;
                if (xfer) state_nxt = last_word ? START : LOAD;
            end
            LOAD: begin
                load_ready_c = 1'b1;
                if (xfer && last_word) state_nxt = START;
            end
            START: begin
                start_c   = 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK:  if (!bus.done) state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.done)  state_nxt = RESULT;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q         <= '0;
            count        <= '0;
            mask         <= '0;
            dig_q        <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            rd_q <= hw_in_range ? ram[bus.mem_addr[AW-1:0]] : '0;

            if (xfer) begin
                count <= first ? CW'(1) : count + CW'(1);
                if (first) begin
                    mask         <= '0;
                    digest_valid <= 1'b0;
                    busy         <= 1'b1;
                end
                if (!load_in_range) err <= 1'b1;
            end

            if (cap) begin
                dig_q[3'd7 - out_off[2:0]] <= bus.mem_write_data;
                mask                       <= mask_now;
            end

            if (bus.mem_we && !(hw_phase && hw_in_range)) err <= 1'b1;

            if ((state == WAIT_DONE) && bus.done) begin
                busy <= 1'b0;
                if (mask_now == 8'hFF) digest_valid <= 1'b1;
                else                   err          <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: drives the load stream and a hasher model,
// scoreboarding read data and checking digest, flags and handshake timing.
module tb_sha_mem_responder;
    localparam int NW = 20;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } rd_vec_t;

    logic         clk;
    logic         reset;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
    logic         err;

    sha_mem_responder_if bus ();

    sha_mem_responder #(
        .DEPTH        (256),
        .NUM_OF_WORDS (NW),
        .MSG_BASE     (16'h0000),
        .OUT_BASE     (16'h0040)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  rdq [$];
    logic [31:0]  mram [256];
    logic [255:0] exp_dig;
    logic [7:0]   emask;
    logic         exp_err;
    rd_vec_t      tbl [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (rdq.size() > 0) begin
            e = rdq.pop_front();
            chk("rd_data", bus.mem_read_data, e);
        end
    endtask

    function automatic logic [31:0] pat(input int k, input logic [31:0] seed);
        return (32'h11111111 * (k + 1)) ^ seed;
    endfunction

    task automatic rd(input logic [15:0] a);
        bus.mem_addr = a;
        rdq.push_back((a < 16'd256) ? mram[a[7:0]] : 32'h0);
        step();
    endtask

    task automatic do_reset(input string tag);
        bus.load_valid = 1'b0;
        bus.mem_we     = 1'b0;
        bus.done       = 1'b1;
        reset          = 1'b1;
        rdq.delete();
        exp_dig = '0;
        exp_err = 1'b0;
        emask   = '0;
        #2;
        chk({tag, "_start"},        bus.start,         1'b0);
        chk({tag, "_digest"},       digest,            exp_dig);
        chk({tag, "_digest_valid"}, digest_valid,      1'b0);
        chk({tag, "_err"},          err,               1'b0);
        chk({tag, "_busy"},         busy,              1'b0);
        chk({tag, "_rdata"},        bus.mem_read_data, 32'h0);
        chk({tag, "_load_ready"},   bus.load_ready,    1'b1);
        chk({tag, "_msg_addr"},     bus.message_addr,  16'h0000);
        chk({tag, "_out_addr"},     bus.output_addr,   16'h0040);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Streams NW words base+i; optional idle cycle between words.
    task automatic load_msg(input logic [31:0] base, input bit toggle, output int ready_cycles);
        int   n;
        int   cyc;
        logic v;
        logic rdy;
        n = 0;
        cyc = 0;
        ready_cycles = 0;
        emask = '0;
        while (n < NW && cyc < 200) begin
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.load_valid = v;
            bus.load_data  = base + 32'(n);
            rdy = bus.load_ready;
            if (rdy) ready_cycles++;
            step();
            if (v && rdy) begin
                mram[n] = base + 32'(n);
                n++;
            end
            cyc++;
        end
        bus.load_valid = 1'b0;
        chk("load_count", n, NW);
        chk("start_after_last", bus.start, 1'b1);
        chk("busy_loaded", busy, 1'b1);
        chk("ready_in_start", bus.load_ready, 1'b0);
        step();
        chk("start_one_cycle", bus.start, 1'b0);
    endtask

    task automatic hw_ack();
        bus.done = 1'b0;
        step();
    endtask

    task automatic hw_model_write(input logic [15:0] a, input logic [31:0] d);
        int k;
        bus.mem_we         = 1'b1;
        bus.mem_addr       = a;
        bus.mem_write_data = d;
        if (a < 16'd256) begin
            mram[a[7:0]] = d;
            if (a >= 16'h0040 && a <= 16'h0047) begin
                k = int'(a - 16'h0040);
                exp_dig[255 - 32*k -: 32] = d;
                emask[k] = 1'b1;
            end
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic hw_write(input logic [15:0] a, input logic [31:0] d);
        hw_model_write(a, d);
        step();
        bus.mem_we = 1'b0;
    endtask

    task automatic hw_finish(input bit with_wr, input logic [15:0] a, input logic [31:0] d);
        logic exp_dv;
        chk("dv_before_done", digest_valid, 1'b0);
        if (with_wr) hw_model_write(a, d);
        bus.done = 1'b1;
        exp_dv = (emask == 8'hFF);
        if (!exp_dv) exp_err = 1'b1;
        step();
        bus.mem_we = 1'b0;
        chk("digest", digest, exp_dig);
        chk("digest_valid", digest_valid, exp_dv);
        chk("err", err, exp_err);
        chk("busy_result", busy, 1'b0);
        chk("ready_result", bus.load_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;

        for (int i = 0; i < NW; i++) tbl.push_back('{16'(i), 32'(i)});
        for (int k = 0; k < 8; k++)  tbl.push_back('{16'(16'h0040 + k), pat(k, 32'h0)});
        tbl.push_back('{16'h0100, 32'h0});
        tbl.push_back('{16'hFFFF, 32'h0});
        tbl.push_back('{16'h0003, 32'h3});

        bus.load_valid = 1'b0;
        bus.load_data = '0;
        bus.done = 1'b1;
        bus.mem_we = 1'b0;
        bus.mem_addr = '0;
        bus.mem_write_data = '0;
        reset = 1'b1;
        do_reset("por");

        // Run 1: held-valid load, full digest write.
        load_msg(32'h0, 1'b0, rc);
        chk("ready_cycles", rc, NW);
        hw_ack();
        for (int k = 0; k < 8; k++) hw_write(16'(16'h0040 + k), pat(k, 32'h0));
        hw_finish(1'b0, '0, '0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.mem_addr = tbl[i].addr;
            rdq.push_back(tbl[i].data);
            step();
        end

        // Run 2: toggled valid, h7 missing, extra load_valid while hashing.
        load_msg(32'h100, 1'b1, rc);
        hw_ack();
        for (int k = 0; k < 4; k++) hw_write(16'(16'h0040 + k), pat(k, 32'hA5A5_0000));
        bus.load_valid = 1'b1;
        chk("ready_in_wait_done", bus.load_ready, 1'b0);
        step();
        bus.load_valid = 1'b0;
        chk("busy_wait_done", busy, 1'b1);
        for (int k = 4; k < 7; k++) hw_write(16'(16'h0040 + k), pat(k, 32'hA5A5_0000));
        hw_finish(1'b0, '0, '0);
        rd(16'h0005);
        rd(16'h0013);

        // Run 3: clean, last write coincides with done; err stays sticky.
        load_msg(32'h200, 1'b0, rc);
        hw_ack();
        for (int k = 0; k < 7; k++) hw_write(16'(16'h0040 + k), pat(k, 32'h0000_5A5A));
        hw_finish(1'b1, 16'h0047, pat(7, 32'h0000_5A5A));

        // Hasher write while IDLE is dropped.
        do_reset("rst2");
        bus.mem_we = 1'b1;
        bus.mem_addr = 16'h0040;
        bus.mem_write_data = 32'hDEADBEEF;
        rdq.push_back(mram[8'h40]);
        step();
        bus.mem_we = 1'b0;
        chk("err_idle_write", err, 1'b1);
        rd(16'h0040);

        // Run 4: out-of-range hasher write during WAIT_DONE.
        do_reset("rst3");
        load_msg(32'h300, 1'b0, rc);
        hw_ack();
        hw_write(16'h0100, 32'hBAD0BAD0);
        chk("err_oor_write", err, 1'b1);
        for (int k = 0; k < 8; k++) hw_write(16'(16'h0040 + k), pat(k, 32'h0303_0303));
        hw_finish(1'b0, '0, '0);
        rd(16'h0100);
        rd(16'h0047);

        // Run 5: reset mid-hash after four digest writes, then fresh run 6.
        load_msg(32'h400, 1'b0, rc);
        hw_ack();
        for (int k = 0; k < 4; k++) hw_write(16'(16'h0040 + k), pat(k, 32'h0404_0404));
        do_reset("abort");
        load_msg(32'h500, 1'b0, rc);
        chk("ready_cycles_r6", rc, NW);
        hw_ack();
        for (int k = 7; k >= 0; k--) hw_write(16'(16'h0040 + k), pat(k, 32'h0606_0606));
        hw_finish(1'b0, '0, '0);
        rd(16'h0000);
        rd(16'h0013);
        rd(16'h0043);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
